// File: rtl/exec_func_units_if.sv
// exec_func_units_if: issue/result bundle between the reservation stations,
// the ROB and the execution back end.
//   in_rs_alu_*  : ALU issue (strobe, opcode, operands, tag, flags, cond code)
//   in_rs_ls_*   : load/store issue (strobe, opcode, address, store data, tag)
//   out_rs_*     : per-unit issue ready
//   out_rob_*    : shared result bus (done pulse, tag, value, flags)
//   out_alu_condition : condition evaluation of the ALU result
// slave = execution units, master = issue/ROB side.
interface exec_func_units_if #(
  parameter int GPR_SIZE     = 64,
  parameter int ROB_IDX_SIZE = 3
);
  logic                    in_rs_alu_start;
  logic [4:0]              in_rs_alu_fu_op;
  logic [GPR_SIZE-1:0]     in_rs_alu_val_a;
  logic [GPR_SIZE-1:0]     in_rs_alu_val_b;
  logic [ROB_IDX_SIZE-1:0] in_rs_alu_dst_rob_index;
  logic                    in_rs_alu_set_nzcv;
  logic [3:0]              in_rs_alu_nzcv;
  logic [3:0]              in_rob_alu_cond_codes;
  logic                    in_rs_ls_start;
  logic [4:0]              in_rs_ls_fu_op;
  logic [GPR_SIZE-1:0]     in_rs_ls_val_a;
  logic [GPR_SIZE-1:0]     in_rs_ls_val_b;
  logic [ROB_IDX_SIZE-1:0] in_rs_ls_dst_rob_index;
  logic                    out_rs_alu_ready;
  logic                    out_rs_ls_ready;
  logic                    out_rob_done;
  logic [ROB_IDX_SIZE-1:0] out_rob_dst_rob_index;
  logic [GPR_SIZE-1:0]     out_rob_value;
  logic                    out_rob_set_nzcv;
  logic [3:0]              out_rob_nzcv;
  logic                    out_alu_condition;

  modport master (
    output in_rs_alu_start, in_rs_alu_fu_op, in_rs_alu_val_a, in_rs_alu_val_b,
           in_rs_alu_dst_rob_index, in_rs_alu_set_nzcv, in_rs_alu_nzcv,
           in_rob_alu_cond_codes, in_rs_ls_start, in_rs_ls_fu_op,
           in_rs_ls_val_a, in_rs_ls_val_b, in_rs_ls_dst_rob_index,
    input  out_rs_alu_ready, out_rs_ls_ready, out_rob_done,
           out_rob_dst_rob_index, out_rob_value, out_rob_set_nzcv,
           out_rob_nzcv, out_alu_condition
  );

  modport slave (
    input  in_rs_alu_start, in_rs_alu_fu_op, in_rs_alu_val_a, in_rs_alu_val_b,
           in_rs_alu_dst_rob_index, in_rs_alu_set_nzcv, in_rs_alu_nzcv,
           in_rob_alu_cond_codes, in_rs_ls_start, in_rs_ls_fu_op,
           in_rs_ls_val_a, in_rs_ls_val_b, in_rs_ls_dst_rob_index,
    output out_rs_alu_ready, out_rs_ls_ready, out_rob_done,
           out_rob_dst_rob_index, out_rob_value, out_rob_set_nzcv,
           out_rob_nzcv, out_alu_condition
  );
endinterface

// File: rtl/exec_func_units.sv
// exec_func_units: single-cycle ALU plus load/store unit with private data
// memory, sharing one registered result bus to the ROB.
//   in_clk : clock, rising edge
//   in_rst : synchronous active-high reset (clears memory, buffer, outputs)
//   bus    : exec_func_units_if.slave -- issue ports in, result bus out
// ALU wins the result bus; a colliding LS result waits in a one-entry buffer,
// and the LS port stalls (ready=0) while that buffer is occupied.
module exec_func_units #(
  parameter int GPR_SIZE     = 64,
  parameter int ROB_IDX_SIZE = 3,
  parameter int MEM_WORDS    = 64
) (
  input logic             in_clk,
  input logic             in_rst,
  exec_func_units_if.slave bus
);
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int SH_W  = $clog2(GPR_SIZE);
  localparam int MSB   = GPR_SIZE - 1;

  localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_AND = 5'd2,
                         OP_ORR = 5'd3,  OP_EOR = 5'd4,  OP_MOV = 5'd5,
                         OP_LSL = 5'd6,  OP_LSR = 5'd7,  OP_ASR = 5'd8,
                         OP_CSEL = 5'd9, OP_CSINC = 5'd10, OP_CSINV = 5'd11,
                         OP_CSNEG = 5'd12, OP_BCOND = 5'd13, OP_PASS = 5'd14,
                         OP_MVN = 5'd15, OP_LDUR = 5'd16, OP_STUR = 5'd17;

  typedef struct packed {
    logic                    done;
    logic [ROB_IDX_SIZE-1:0] tag;
    logic [GPR_SIZE-1:0]     value;
    logic                    set_nzcv;
    logic [3:0]              nzcv;
    logic                    cond;
  } res_t;

  res_t                res_q, res_d, buf_q, buf_d, alu_res, ls_res, ls_pend;
  logic [GPR_SIZE-1:0] mem_q [MEM_WORDS];
  logic                alu_rdy, ls_rdy, alu_fire, ls_fire, ls_is_st, cond;
  logic [IDX_W-1:0]    ls_idx;
  logic [GPR_SIZE:0]   add_w, sub_w;
  logic [GPR_SIZE-1:0] a, b, val;
  logic                fn, fz, fc, fv, c_o, v_o, t;
  logic                unused_bits;

  assign alu_rdy  = ~in_rst;
  assign ls_rdy   = ~in_rst & ~buf_q.done;
  // Opcodes for the other unit are silently dropped.
  assign alu_fire = bus.in_rs_alu_start & alu_rdy & (bus.in_rs_alu_fu_op <= OP_MVN);
  assign ls_is_st = (bus.in_rs_ls_fu_op == OP_STUR);
  assign ls_fire  = bus.in_rs_ls_start & ls_rdy &
                    ((bus.in_rs_ls_fu_op == OP_LDUR) | ls_is_st);
  assign ls_idx   = bus.in_rs_ls_val_a[IDX_W+2:3];
  assign unused_bits = ^{bus.in_rs_ls_val_a[GPR_SIZE-1:IDX_W+3],
                         bus.in_rs_ls_val_a[2:0]};

  // Condition: cc[3:1] picks the test, cc[0] inverts it, except 111x (always).
  always_comb begin
    {fn, fz, fc, fv} = bus.in_rs_alu_nzcv;
    case (bus.in_rob_alu_cond_codes[3:1])
      3'd0:    t = fz;
      3'd1:    t = fc;
      3'd2:    t = fn;
      3'd3:    t = fv;
      3'd4:    t = fc & ~fz;
      3'd5:    t = (fn == fv);
      3'd6:    t = ~fz & (fn == fv);
      default: t = 1'b1;
    endcase
    cond = (bus.in_rob_alu_cond_codes[3:1] == 3'd7) ? 1'b1
                                                    : t ^ bus.in_rob_alu_cond_codes[0];
  end

  always_comb begin
    a     = bus.in_rs_alu_val_a;
    b     = bus.in_rs_alu_val_b;
    add_w = {1'b0, a} + {1'b0, b};
    sub_w = {1'b0, a} + {1'b0, ~b} + {{GPR_SIZE{1'b0}}, 1'b1};
    case (bus.in_rs_alu_fu_op)
      OP_ADD:   val = add_w[MSB:0];
      OP_SUB:   val = sub_w[MSB:0];
      OP_AND:   val = a & b;
      OP_ORR:   val = a | b;
      OP_EOR:   val = a ^ b;
      OP_MOV:   val = b;
      OP_LSL:   val = a << b[SH_W-1:0];
      OP_LSR:   val = a >> b[SH_W-1:0];
      OP_ASR:   val = $signed(a) >>> b[SH_W-1:0];
      OP_CSEL:  val = cond ? a : b;
      OP_CSINC: val = cond ? a : b + {{MSB{1'b0}}, 1'b1};
      OP_CSINV: val = cond ? a : ~b;
      OP_CSNEG: val = cond ? a : '0 - b;
      OP_PASS:  val = a;
      OP_MVN:   val = ~b;
      default:  val = '0;   // BCOND and dropped opcodes
    endcase
    c_o = fc;
    v_o = fv;
    case (bus.in_rs_alu_fu_op)
      OP_ADD: begin
        c_o = add_w[GPR_SIZE];
        v_o = (a[MSB] == b[MSB]) & (val[MSB] != a[MSB]);
      end
      OP_SUB: begin
        c_o = sub_w[GPR_SIZE];
        v_o = (a[MSB] != b[MSB]) & (val[MSB] != a[MSB]);
      end
      OP_AND: begin
        c_o = 1'b0;
        v_o = 1'b0;
      end
      default: ;
    endcase
    alu_res          = '0;
    alu_res.done     = 1'b1;
    alu_res.tag      = bus.in_rs_alu_dst_rob_index;
    alu_res.value    = val;
    alu_res.set_nzcv = bus.in_rs_alu_set_nzcv;
    alu_res.nzcv     = bus.in_rs_alu_set_nzcv ? {val[MSB], val == '0, c_o, v_o}
                                              : bus.in_rs_alu_nzcv;
    alu_res.cond     = cond;
  end

  // Stores complete with value 0 so the ROB can retire them.
  always_comb begin
    ls_res       = '0;
    ls_res.done  = 1'b1;
    ls_res.tag   = bus.in_rs_ls_dst_rob_index;
    ls_res.value = ls_is_st ? '0 : mem_q[ls_idx];
  end

  // Buffered LS result and a new LS issue are exclusive (ls_rdy gates issue).
  always_comb begin
    ls_pend = buf_q.done ? buf_q : (ls_fire ? ls_res : '0);
    if (alu_fire) begin
      res_d = alu_res;
      buf_d = ls_pend;
    end else begin
      res_d = ls_pend;
      buf_d = '0;
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      res_q <= '0;
      buf_q <= '0;
      for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
    end else begin
      res_q <= res_d;
      buf_q <= buf_d;
      if (ls_fire && ls_is_st) mem_q[ls_idx] <= bus.in_rs_ls_val_b;
    end
  end

  assign bus.out_rs_alu_ready      = alu_rdy;
  assign bus.out_rs_ls_ready       = ls_rdy;
  assign bus.out_rob_done          = res_q.done;
  assign bus.out_rob_dst_rob_index = res_q.tag;
  assign bus.out_rob_value         = res_q.value;
  assign bus.out_rob_set_nzcv      = res_q.set_nzcv;
  assign bus.out_rob_nzcv          = res_q.nzcv;
  assign bus.out_alu_condition     = res_q.cond;
endmodule

// File: tb/tb_exec_func_units.sv
// Bench for exec_func_units: directed ALU vector table, hand-written
// store/load, collision, routing and reset sequences, then randomized issue
// checked against a queue-based reference model.
module tb_exec_func_units;
  logic in_clk = 1'b0;
  logic in_rst = 1'b1;
  always #5 in_clk = ~in_clk;

  exec_func_units_if #(.GPR_SIZE(64), .ROB_IDX_SIZE(3)) bus();
  exec_func_units #(.GPR_SIZE(64), .ROB_IDX_SIZE(3), .MEM_WORDS(64)) dut (
    .in_clk(in_clk), .in_rst(in_rst), .bus(bus));

  typedef struct packed {
    logic        done;
    logic [2:0]  tag;
    logic [63:0] value;
    logic        setf;
    logic [3:0]  nzcv;
    logic        cond;
  } res_t;

  typedef struct {
    logic [4:0]  op;
    logic [63:0] a, b;
    logic        setf;
    logic [3:0]  f, cc;
    logic [63:0] ev;
    logic [3:0]  en;
    logic        ec;
  } vec_t;

  int checks = 0, errors = 0;
  vec_t vecs[$];
  res_t lsq[$];
  res_t exp_out;
  logic [63:0] m_mem [64];
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SMIN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] SMAX = 64'h7FFF_FFFF_FFFF_FFFF;

  task automatic chk_res(input string name, input res_t act, input res_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (done,tag,value,set,nzcv,cond)", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic res_t dut_out();
    return {bus.out_rob_done, bus.out_rob_dst_rob_index, bus.out_rob_value,
            bus.out_rob_set_nzcv, bus.out_rob_nzcv, bus.out_alu_condition};
  endfunction

  function automatic res_t mk(input logic [2:0] tag, input logic [63:0] v,
                              input logic s, input logic [3:0] f, input logic c);
    return {1'b1, tag, v, s, f, c};
  endfunction

  // Reference ALU written directly from the opcode/flag/condition rules.
  function automatic res_t ref_alu(input logic [4:0] op, input logic [63:0] a, b,
                                   input logic setf, input logic [3:0] f, cc,
                                   input logic [2:0] tag);
    logic n, z, c, v, t, co, vo;
    logic [63:0] r;
    {n, z, c, v} = f;
    case (cc)
      4'd0: t = z;           4'd1: t = !z;
      4'd2: t = c;           4'd3: t = !c;
      4'd4: t = n;           4'd5: t = !n;
      4'd6: t = v;           4'd7: t = !v;
      4'd8: t = c && !z;     4'd9: t = !c || z;
      4'd10: t = (n == v);   4'd11: t = (n != v);
      4'd12: t = !z && (n == v);
      4'd13: t = z || (n != v);
      default: t = 1'b1;
    endcase
    co = c; vo = v;
    case (op)
      5'd0: begin r = a + b; co = (r < a);
                  vo = (a[63] == b[63]) && (r[63] != a[63]); end
      5'd1: begin r = a - b; co = (a >= b);
                  vo = (a[63] != b[63]) && (r[63] != a[63]); end
      5'd2: begin r = a & b; co = 1'b0; vo = 1'b0; end
      5'd3: r = a | b;
      5'd4: r = a ^ b;
      5'd5: r = b;
      5'd6: r = a << b[5:0];
      5'd7: r = a >> b[5:0];
      5'd8: r = $signed(a) >>> b[5:0];
      5'd9: r = t ? a : b;
      5'd10: r = t ? a : b + 64'd1;
      5'd11: r = t ? a : ~b;
      5'd12: r = t ? a : -b;
      5'd14: r = a;
      5'd15: r = ~b;
      default: r = 64'd0;
    endcase
    return {1'b1, tag, r, setf, setf ? {r[63], r == 64'd0, co, vo} : f, t};
  endfunction

  task automatic addv(input logic [4:0] op, input logic [63:0] a, b, input logic setf,
                      input logic [3:0] f, cc, input logic [63:0] ev,
                      input logic [3:0] en, input logic ec);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.setf = setf; v.f = f; v.cc = cc;
    v.ev = ev; v.en = en; v.ec = ec;
    vecs.push_back(v);
  endtask

  task automatic idle();
    bus.in_rs_alu_start = 1'b0; bus.in_rs_alu_fu_op = 5'd0;
    bus.in_rs_alu_val_a = 64'd0; bus.in_rs_alu_val_b = 64'd0;
    bus.in_rs_alu_dst_rob_index = 3'd0; bus.in_rs_alu_set_nzcv = 1'b0;
    bus.in_rs_alu_nzcv = 4'd0; bus.in_rob_alu_cond_codes = 4'd0;
    bus.in_rs_ls_start = 1'b0; bus.in_rs_ls_fu_op = 5'd0;
    bus.in_rs_ls_val_a = 64'd0; bus.in_rs_ls_val_b = 64'd0;
    bus.in_rs_ls_dst_rob_index = 3'd0;
  endtask

  task automatic drive_alu(input logic [4:0] op, input logic [63:0] a, b,
                           input logic setf, input logic [3:0] f, cc, input logic [2:0] tag);
    bus.in_rs_alu_start = 1'b1; bus.in_rs_alu_fu_op = op;
    bus.in_rs_alu_val_a = a; bus.in_rs_alu_val_b = b;
    bus.in_rs_alu_set_nzcv = setf; bus.in_rs_alu_nzcv = f;
    bus.in_rob_alu_cond_codes = cc; bus.in_rs_alu_dst_rob_index = tag;
  endtask

  task automatic drive_ls(input logic [4:0] op, input logic [63:0] a, b, input logic [2:0] tag);
    bus.in_rs_ls_start = 1'b1; bus.in_rs_ls_fu_op = op;
    bus.in_rs_ls_val_a = a; bus.in_rs_ls_val_b = b; bus.in_rs_ls_dst_rob_index = tag;
  endtask

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  initial begin
    // op, a, b, setf, nzcv_in, cc, expected value, expected nzcv, expected cond
    addv(5'd0, 64'd5, 64'd7, 1'b1, 4'b0000, 4'd14, 64'd12, 4'b0000, 1'b1);
    addv(5'd1, 64'd3, 64'd3, 1'b1, 4'b0000, 4'd14, 64'd0, 4'b0110, 1'b1);
    addv(5'd1, 64'd0, 64'd1, 1'b1, 4'b0000, 4'd14, ONES, 4'b1000, 1'b1);
    addv(5'd9, 64'd11, 64'd22, 1'b0, 4'b1001, 4'd10, 64'd11, 4'b1001, 1'b1);
    addv(5'd9, 64'd11, 64'd22, 1'b0, 4'b1000, 4'd10, 64'd22, 4'b1000, 1'b0);
    addv(5'd0, SMAX, 64'd1, 1'b1, 4'b0000, 4'd14, SMIN, 4'b1001, 1'b1);
    addv(5'd0, ONES, 64'd1, 1'b1, 4'b0000, 4'd14, 64'd0, 4'b0110, 1'b1);
    addv(5'd1, SMIN, 64'd1, 1'b1, 4'b0000, 4'd14, SMAX, 4'b0011, 1'b1);
    addv(5'd2, 64'hF0, 64'h0F, 1'b1, 4'b1111, 4'd14, 64'd0, 4'b0100, 1'b1);
    addv(5'd3, 64'hF0, 64'h0F, 1'b0, 4'b0101, 4'd14, 64'hFF, 4'b0101, 1'b1);
    addv(5'd4, 64'hFF, 64'h0F, 1'b1, 4'b0011, 4'd14, 64'hF0, 4'b0011, 1'b1);
    addv(5'd5, 64'd1, 64'h1234, 1'b0, 4'b0000, 4'd14, 64'h1234, 4'b0000, 1'b1);
    addv(5'd6, 64'd1, 64'h44, 1'b0, 4'b0000, 4'd14, 64'd16, 4'b0000, 1'b1);
    addv(5'd7, 64'h100, 64'd8, 1'b0, 4'b0000, 4'd14, 64'd1, 4'b0000, 1'b1);
    addv(5'd8, SMIN, 64'd63, 1'b1, 4'b0011, 4'd14, ONES, 4'b1011, 1'b1);
    addv(5'd10, 64'd5, 64'd9, 1'b0, 4'b0000, 4'd0, 64'd10, 4'b0000, 1'b0);
    addv(5'd12, 64'd5, 64'd9, 1'b0, 4'b0000, 4'd1, 64'd5, 4'b0000, 1'b1);
    addv(5'd12, 64'd5, 64'd9, 1'b0, 4'b0100, 4'd1, 64'hFFFF_FFFF_FFFF_FFF7, 4'b0100, 1'b0);
    addv(5'd11, 64'd1, 64'd0, 1'b0, 4'b0010, 4'd9, ONES, 4'b0010, 1'b0);
    addv(5'd15, 64'd0, 64'd0, 1'b1, 4'b0000, 4'd14, ONES, 4'b1000, 1'b1);
    addv(5'd13, 64'd3, 64'd4, 1'b0, 4'b0000, 4'd15, 64'd0, 4'b0000, 1'b1);
    addv(5'd14, 64'h55, 64'd1, 1'b0, 4'b0000, 4'd14, 64'h55, 4'b0000, 1'b1);
    addv(5'd9, 64'd1, 64'd2, 1'b0, 4'b0010, 4'd8, 64'd1, 4'b0010, 1'b1);
    addv(5'd9, 64'd1, 64'd2, 1'b0, 4'b0100, 4'd12, 64'd2, 4'b0100, 1'b0);

    // Reset behaviour
    idle();
    #1;
    chk_b("rst_alu_rdy", bus.out_rs_alu_ready, 1'b0);
    chk_b("rst_ls_rdy", bus.out_rs_ls_ready, 1'b0);
    tick();
    chk_res("rst_out", dut_out(), '0);
    in_rst = 1'b0;
    #1;
    chk_b("post_rst_alu_rdy", bus.out_rs_alu_ready, 1'b1);
    chk_b("post_rst_ls_rdy", bus.out_rs_ls_ready, 1'b1);

    // Back-to-back ALU vectors: a result every cycle
    foreach (vecs[i]) begin
      drive_alu(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].setf, vecs[i].f, vecs[i].cc, 3'(i));
      tick();
      chk_res($sformatf("vec%0d", i), dut_out(),
              mk(3'(i), vecs[i].ev, vecs[i].setf, vecs[i].en, vecs[i].ec));
    end
    idle();
    tick();
    chk_res("alu_idle", dut_out(), '0);

    // Store then load from the same word on the next cycle
    drive_ls(5'd17, 64'h10, 64'hDEAD, 3'd1);
    tick();
    chk_res("stur", dut_out(), mk(3'd1, 64'd0, 1'b0, 4'd0, 1'b0));
    drive_ls(5'd16, 64'h17, 64'd0, 3'd4);   // low bits ignored
    tick();
    chk_res("ldur", dut_out(), mk(3'd4, 64'hDEAD, 1'b0, 4'd0, 1'b0));

    // Cross-routed opcodes are dropped
    idle();
    drive_alu(5'd16, 64'h10, 64'd0, 1'b0, 4'd0, 4'd14, 3'd2);
    drive_ls(5'd0, 64'd1, 64'd2, 3'd3);
    tick();
    chk_res("route_drop", dut_out(), '0);

    // Collision: ALU first, LS one cycle later, LS port stalled meanwhile
    idle();
    drive_alu(5'd0, 64'd1, 64'd1, 1'b0, 4'd0, 4'd14, 3'd3);
    drive_ls(5'd16, 64'h10, 64'd0, 3'd5);
    tick();
    idle();
    chk_res("coll_alu", dut_out(), mk(3'd3, 64'd2, 1'b0, 4'd0, 1'b1));
    #1;
    chk_b("coll_ls_rdy", bus.out_rs_ls_ready, 1'b0);
    tick();
    chk_res("coll_ls", dut_out(), mk(3'd5, 64'hDEAD, 1'b0, 4'd0, 1'b0));
    chk_b("coll_ls_rdy_after", bus.out_rs_ls_ready, 1'b1);
    tick();
    chk_res("coll_idle", dut_out(), '0);

    // Buffered result held while the ALU keeps the bus busy
    drive_alu(5'd14, 64'd7, 64'd0, 1'b0, 4'd0, 4'd14, 3'd1);
    drive_ls(5'd16, 64'h10, 64'd0, 3'd6);
    tick();
    bus.in_rs_ls_start = 1'b0;
    drive_alu(5'd14, 64'd8, 64'd0, 1'b0, 4'd0, 4'd14, 3'd2);
    tick();
    idle();
    chk_res("hold_alu2", dut_out(), mk(3'd2, 64'd8, 1'b0, 4'd0, 1'b1));
    tick();
    chk_res("hold_ls", dut_out(), mk(3'd6, 64'hDEAD, 1'b0, 4'd0, 1'b0));

    // Reset with an LS result sitting in the buffer
    drive_alu(5'd14, 64'd9, 64'd0, 1'b0, 4'd0, 4'd14, 3'd1);
    drive_ls(5'd16, 64'h10, 64'd0, 3'd7);
    tick();
    idle();
    in_rst = 1'b1;
    #1;
    chk_b("midrst_alu_rdy", bus.out_rs_alu_ready, 1'b0);
    chk_b("midrst_ls_rdy", bus.out_rs_ls_ready, 1'b0);
    tick();
    chk_res("midrst_out", dut_out(), '0);
    in_rst = 1'b0;
    #1;
    chk_b("midrst_alu_rdy_after", bus.out_rs_alu_ready, 1'b1);
    chk_b("midrst_ls_rdy_after", bus.out_rs_ls_ready, 1'b1);
    drive_ls(5'd16, 64'h10, 64'd0, 3'd2);
    tick();
    idle();
    chk_res("midrst_mem_cleared", dut_out(), mk(3'd2, 64'd0, 1'b0, 4'd0, 1'b0));
    tick();
    chk_res("midrst_no_done", dut_out(), '0);

    // Randomized issue against the reference model
    in_rst = 1'b1;
    tick();
    in_rst = 1'b0;
    exp_out = '0;
    lsq.delete();
    for (int i = 0; i < 64; i++) m_mem[i] = 64'd0;
    for (int n = 0; n < 800; n++) begin
      logic r_rst, a_go, l_go, setf;
      logic [4:0] aop, lop;
      logic [63:0] aa, ab, la, lb;
      logic [3:0] f, cc;
      logic [2:0] atag, ltag;
      res_t lr;
      chk_res("rand_out", dut_out(), exp_out);
      r_rst = ($urandom_range(0, 59) == 0);
      a_go  = ($urandom_range(0, 2) != 0);
      l_go  = ($urandom_range(0, 1) != 0);
      aop   = 5'($urandom_range(0, 19));
      lop   = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 15))
                                          : 5'($urandom_range(16, 17));
      aa    = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
      ab    = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 70)) : {$urandom, $urandom};
      la    = {32'($urandom), 32'($urandom_range(0, 63))};
      lb    = {$urandom, $urandom};
      setf  = 1'($urandom);
      f     = 4'($urandom);
      cc    = 4'($urandom);
      atag  = 3'($urandom);
      ltag  = 3'($urandom);
      idle();
      in_rst = r_rst;
      if (a_go) drive_alu(aop, aa, ab, setf, f, cc, atag);
      if (l_go) drive_ls(lop, la, lb, ltag);
      #1;
      chk_b("rand_alu_rdy", bus.out_rs_alu_ready, !r_rst);
      chk_b("rand_ls_rdy", bus.out_rs_ls_ready, !r_rst && lsq.size() == 0);
      if (r_rst) begin
        exp_out = '0;
        lsq.delete();
        for (int i = 0; i < 64; i++) m_mem[i] = 64'd0;
      end else begin
        if (l_go && lsq.size() == 0 && (lop == 5'd16 || lop == 5'd17)) begin
          lr = {1'b1, ltag, 64'd0, 1'b0, 4'd0, 1'b0};
          if (lop == 5'd17) m_mem[la[8:3]] = lb;
          else lr.value = m_mem[la[8:3]];
          lsq.push_back(lr);
        end
        if (a_go && aop <= 5'd15) exp_out = ref_alu(aop, aa, ab, setf, f, cc, atag);
        else if (lsq.size() != 0) exp_out = lsq.pop_front();
        else exp_out = '0;
      end
      tick();
    end
    chk_res("rand_final", dut_out(), exp_out);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
